// File: rtl/axi_lite_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_req_arbiter
// Brief    : Round-robin arbiter sharing one AXI4-Lite master between two
//            single-beat register requesters.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_req_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [1:0]                REQ_VALID,
    input  logic [1:0]                REQ_WE,
    input  logic [2*ADDR_WIDTH-1:0]   REQ_ADDR,
    input  logic [2*DATA_WIDTH-1:0]   REQ_WDATA,
    input  logic [2*DATA_WIDTH/8-1:0] REQ_WSTRB,
    output logic [1:0]                REQ_READY,
    output logic [1:0]                RSP_VALID,
    output logic [DATA_WIDTH-1:0]     RSP_RDATA,
    output logic [1:0]                RSP_RESP,
    output logic                      BUSY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_WR      = 3'd1;
    localparam logic [2:0] c_ST_WR_RESP = 3'd2;
    localparam logic [2:0] c_ST_RD_ADDR = 3'd3;
    localparam logic [2:0] c_ST_RD_DATA = 3'd4;
    localparam logic [2:0] c_ST_DONE    = 3'd5;

    logic [2:0]            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;

    logic                  w_req_any;
    logic                  w_gnt_idx;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic [DATA_WIDTH-1:0] w_req_wdata;
    logic [STRB_WIDTH-1:0] w_req_wstrb;

    // On a tie the requester that did not win last time is chosen.
    assign w_req_any   = |REQ_VALID;
    assign w_gnt_idx   = (REQ_VALID == 2'b11) ? ~last_grant_q : REQ_VALID[1];
    assign w_req_addr  = w_gnt_idx ? REQ_ADDR[ADDR_WIDTH +: ADDR_WIDTH]
                                   : REQ_ADDR[0 +: ADDR_WIDTH];
    assign w_req_wdata = w_gnt_idx ? REQ_WDATA[DATA_WIDTH +: DATA_WIDTH]
                                   : REQ_WDATA[0 +: DATA_WIDTH];
    assign w_req_wstrb = w_gnt_idx ? REQ_WSTRB[STRB_WIDTH +: STRB_WIDTH]
                                   : REQ_WSTRB[0 +: STRB_WIDTH];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= c_ST_IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            rdata_q      <= '0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        rdata_d      = rdata_q;
        resp_d       = resp_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_req_any) begin
                    gnt_d        = w_gnt_idx;
                    last_grant_d = w_gnt_idx;
                    addr_d       = w_req_addr;
                    wdata_d      = w_req_wdata;
                    wstrb_d      = w_req_wstrb;
                    aw_done_d    = 1'b0;
                    w_done_d     = 1'b0;
                    state_d      = REQ_WE[w_gnt_idx] ? c_ST_WR : c_ST_RD_ADDR;
                end
            end
            c_ST_WR: begin
                // VALID is high exactly while the done flag is clear.
                aw_done_d = aw_done_q | M_AXI_AWREADY;
                w_done_d  = w_done_q | M_AXI_WREADY;
                if (aw_done_d && w_done_d) begin
                    state_d = c_ST_WR_RESP;
                end
            end
            c_ST_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    resp_d  = M_AXI_BRESP;
                    rdata_d = '0;
                    state_d = c_ST_DONE;
                end
            end
            c_ST_RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    state_d = c_ST_RD_DATA;
                end
            end
            c_ST_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA;
                    resp_d  = M_AXI_RRESP;
                    state_d = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                state_d = c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // REQ_READY is gated by reset so it drops asynchronously with the rest.
    always_comb begin
        REQ_READY     = 2'b00;
        RSP_VALID     = 2'b00;
        RSP_RDATA     = '0;
        RSP_RESP      = 2'b00;
        BUSY          = (state_q != c_ST_IDLE);
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        case (state_q)
            c_ST_IDLE: begin
                if (w_req_any && ARESETN) begin
                    REQ_READY[w_gnt_idx] = 1'b1;
                end
            end
            c_ST_WR: begin
                M_AXI_AWVALID = ~aw_done_q;
                M_AXI_WVALID  = ~w_done_q;
            end
            c_ST_WR_RESP: M_AXI_BREADY  = 1'b1;
            c_ST_RD_ADDR: M_AXI_ARVALID = 1'b1;
            c_ST_RD_DATA: M_AXI_RREADY  = 1'b1;
            c_ST_DONE: begin
                RSP_VALID[gnt_q] = 1'b1;
                RSP_RDATA        = rdata_q;
                RSP_RESP         = resp_q;
            end
            default: ;
        endcase
    end

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_ARPROT = 3'b000;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_req_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axi_lite_req_arbiter
// Brief    : Scoreboard bench with two requester drivers and an AXI-Lite slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_req_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } cmd_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  REQ_VALID, REQ_WE, REQ_READY, RSP_VALID, RSP_RESP;
    logic [63:0] REQ_ADDR, REQ_WDATA;
    logic [7:0]  REQ_WSTRB;
    logic [31:0] RSP_RDATA;
    logic        BUSY;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    always #5 clk = ~clk;

    axi_lite_req_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(clk), .ARESETN(rst_n),
        .REQ_VALID(REQ_VALID), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB), .REQ_READY(REQ_READY),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP),
        .BUSY(BUSY),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID),
        .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID),
        .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID),
        .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID),
        .M_AXI_RREADY(RREADY)
    );

    int          checks = 0;
    int          errors = 0;
    cmd_t        cmdq0[$], cmdq1[$];
    exp_t        expq0[$], expq1[$];
    int          grant_log[$];
    cmd_t        slot [2];
    logic [1:0]  slot_v = 2'b00;
    logic [31:0] ref_mem [4];
    bit          model_last = 1'b1;
    int          slave_mode = 0;
    bit          rand_gap = 1'b0;

    // Reference model: four word registers at 0x0..0xC, anything else errors.
    function automatic exp_t model_access(cmd_t c);
        exp_t e;
        e.rdata = 32'h0;
        e.resp  = 2'b00;
        if (c.addr >= 32'h10) begin
            e.resp = 2'b10;
        end else if (c.we) begin
            for (int b = 0; b < 4; b++)
                if (c.strb[b]) ref_mem[c.addr[3:2]][8*b +: 8] = c.wdata[8*b +: 8];
        end else begin
            e.rdata = ref_mem[c.addr[3:2]];
        end
        return e;
    endfunction

    task automatic apply_slots();
        REQ_VALID = slot_v;
        for (int i = 0; i < 2; i++) begin
            REQ_WE[i]              = slot[i].we;
            REQ_ADDR[32*i +: 32]   = slot[i].addr;
            REQ_WDATA[32*i +: 32]  = slot[i].wdata;
            REQ_WSTRB[4*i +: 4]    = slot[i].strb;
        end
    endtask

    // Requester drivers and grant scoreboard push.
    initial begin : p_driver
        logic [1:0] gnt_pend;
        logic [1:0] exp_g;
        bit         w;
        exp_t       e;
        gnt_pend = 2'b00;
        slot[0]  = '0;
        slot[1]  = '0;
        apply_slots();
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                slot_v   = 2'b00;
                gnt_pend = 2'b00;
                apply_slots();
                continue;
            end
            for (int i = 0; i < 2; i++) if (gnt_pend[i]) slot_v[i] = 1'b0;
            gnt_pend = 2'b00;
            if (!slot_v[0] && cmdq0.size() > 0 && (!rand_gap || $urandom_range(1, 0) == 1)) begin
                slot[0] = cmdq0.pop_front(); slot_v[0] = 1'b1;
            end
            if (!slot_v[1] && cmdq1.size() > 0 && (!rand_gap || $urandom_range(1, 0) == 1)) begin
                slot[1] = cmdq1.pop_front(); slot_v[1] = 1'b1;
            end
            apply_slots();
            #1;
            if (slot_v != 2'b00 || REQ_READY != 2'b00) begin
                exp_g = 2'b00;
                w     = 1'b0;
                if (!BUSY && slot_v != 2'b00) begin
                    w = (slot_v == 2'b11) ? !model_last : slot_v[1];
                    exp_g[w] = 1'b1;
                end
                checks++;
                if (REQ_READY !== exp_g) begin
                    errors++;
                    $display("FAIL grant: REQ_READY=%b expected %b (req=%b busy=%b)",
                             REQ_READY, exp_g, slot_v, BUSY);
                end
                if (exp_g != 2'b00) begin
                    e = model_access(slot[w]);
                    if (w) expq1.push_back(e); else expq0.push_back(e);
                    model_last = w;
                    grant_log.push_back(int'(w));
                    gnt_pend = exp_g;
                end
            end
        end
    end

    task automatic check_rsp(int i);
        exp_t e;
        if ((i == 0 && expq0.size() == 0) || (i == 1 && expq1.size() == 0)) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected: RSP_VALID[%0d] with no outstanding grant", i);
            return;
        end
        e = (i == 0) ? expq0.pop_front() : expq1.pop_front();
        checks += 2;
        if (RSP_RDATA !== e.rdata) begin
            errors++;
            $display("FAIL rsp_rdata[%0d]: got %h expected %h", i, RSP_RDATA, e.rdata);
        end
        if (RSP_RESP !== e.resp) begin
            errors++;
            $display("FAIL rsp_resp[%0d]: got %b expected %b", i, RSP_RESP, e.resp);
        end
    endtask

    // Response monitor.
    initial begin : p_monitor
        bit prev_rsp;
        prev_rsp = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin prev_rsp = 1'b0; continue; end
            if (prev_rsp) begin
                checks++;
                if (BUSY !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_gap: BUSY=%b expected 0 after completion", BUSY);
                end
            end
            if (RSP_VALID != 2'b00) begin
                checks++;
                if (RSP_VALID == 2'b11) begin
                    errors++;
                    $display("FAIL rsp_onehot: RSP_VALID=%b expected one bit", RSP_VALID);
                end
                if (RSP_VALID[0]) check_rsp(0);
                if (RSP_VALID[1]) check_rsp(1);
            end
            prev_rsp = (RSP_VALID != 2'b00);
        end
    end

    // AXI-Lite slave with selectable READY/response timing.
    initial begin : p_slave
        bit          rec_aw, rec_w, rec_b, rec_ar, rec_r;
        logic [31:0] rec_awaddr, rec_wdata, rec_araddr;
        logic [3:0]  rec_wstrb;
        bit          aw_got, w_got, b_pend, ar_got;
        logic [31:0] s_awaddr, s_wdata, s_araddr;
        logic [3:0]  s_wstrb;
        int          b_cnt, r_cnt, since;
        logic [31:0] mem [4];
        bit          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bready;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        logic [3:0]  p_wstrb;
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        {rec_aw, rec_w, rec_b, rec_ar, rec_r} = '0;
        {aw_got, w_got, b_pend, ar_got} = '0;
        {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bready} = '0;
        {rec_awaddr, rec_wdata, rec_araddr, rec_wstrb} = '0;
        {s_awaddr, s_wdata, s_araddr, s_wstrb} = '0;
        {p_awaddr, p_wdata, p_araddr, p_wstrb} = '0;
        b_cnt = 0; r_cnt = 0; since = 0;
        {AWREADY, WREADY, BVALID, ARREADY, RVALID} = '0;
        BRESP = 2'b00; RRESP = 2'b00; RDATA = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                rec_aw = AWVALID && AWREADY;
                rec_w  = WVALID && WREADY;
                rec_b  = BVALID && BREADY;
                rec_ar = ARVALID && ARREADY;
                rec_r  = RVALID && RREADY;
                if (rec_aw) begin
                    checks++;
                    if (aw_got || AWPROT != 3'b000) begin
                        errors++;
                        $display("FAIL aw_handshake: dup=%b prot=%b expected 0/000", aw_got, AWPROT);
                    end
                    rec_awaddr = AWADDR;
                end
                if (rec_w) begin
                    checks++;
                    if (w_got) begin
                        errors++;
                        $display("FAIL w_handshake: duplicate W beat, got 1 expected 0");
                    end
                    rec_wdata = WDATA; rec_wstrb = WSTRB;
                end
                if (rec_ar) begin
                    checks++;
                    if (ARPROT != 3'b000) begin
                        errors++;
                        $display("FAIL arprot: got %b expected 000", ARPROT);
                    end
                    rec_araddr = ARADDR;
                end
                if (BREADY && !p_bready) begin
                    checks++;
                    if (!(aw_got && w_got)) begin
                        errors++;
                        $display("FAIL bready_early: aw=%b w=%b expected both 1", aw_got, w_got);
                    end
                end
                if (AWVALID && p_awv && !p_awr) begin
                    checks++;
                    if (AWADDR !== p_awaddr) begin
                        errors++;
                        $display("FAIL aw_stable: got %h expected %h", AWADDR, p_awaddr);
                    end
                end
                if (WVALID && p_wv && !p_wr) begin
                    checks++;
                    if (WDATA !== p_wdata || WSTRB !== p_wstrb) begin
                        errors++;
                        $display("FAIL w_stable: got %h/%h expected %h/%h", WDATA, WSTRB, p_wdata, p_wstrb);
                    end
                end
                if (ARVALID && p_arv && !p_arr) begin
                    checks++;
                    if (ARADDR !== p_araddr) begin
                        errors++;
                        $display("FAIL ar_stable: got %h expected %h", ARADDR, p_araddr);
                    end
                end
                p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
                p_wv = WVALID; p_wr = WREADY; p_wdata = WDATA; p_wstrb = WSTRB;
                p_arv = ARVALID; p_arr = ARREADY; p_araddr = ARADDR;
                p_bready = BREADY;
            end else begin
                {rec_aw, rec_w, rec_b, rec_ar, rec_r} = '0;
                {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bready} = '0;
            end
            @(posedge clk); #1;
            if (!rst_n) begin
                {aw_got, w_got, b_pend, ar_got} = '0;
                {AWREADY, WREADY, BVALID, ARREADY, RVALID} = '0;
                BRESP = 2'b00; RRESP = 2'b00; RDATA = 32'h0;
                b_cnt = 0; r_cnt = 0; since = 0;
                continue;
            end
            if (rec_b) begin BVALID = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; end
            if (rec_r) begin RVALID = 1'b0; ar_got = 1'b0; RDATA = 32'h0; RRESP = 2'b00; end
            if (rec_aw) begin aw_got = 1'b1; s_awaddr = rec_awaddr; end
            if (rec_w) begin w_got = 1'b1; s_wdata = rec_wdata; s_wstrb = rec_wstrb; end
            if (rec_ar) begin
                ar_got = 1'b1; s_araddr = rec_araddr;
                r_cnt = (slave_mode == 4) ? 1000 : (slave_mode == 1) ? int'($urandom_range(2, 0)) : 0;
            end
            if (aw_got && w_got && !b_pend) begin
                b_pend = 1'b1;
                b_cnt  = (slave_mode == 1) ? int'($urandom_range(2, 0)) : 0;
            end
            if (b_pend && !BVALID) begin
                if (b_cnt == 0) begin
                    BVALID = 1'b1;
                    if (s_awaddr < 32'h10) begin
                        for (int b = 0; b < 4; b++)
                            if (s_wstrb[b]) mem[s_awaddr[3:2]][8*b +: 8] = s_wdata[8*b +: 8];
                        BRESP = 2'b00;
                    end else begin
                        BRESP = 2'b10;
                    end
                end else begin
                    b_cnt--;
                end
            end
            if (ar_got && !RVALID) begin
                if (r_cnt == 0) begin
                    RVALID = 1'b1;
                    RDATA  = (s_araddr < 32'h10) ? mem[s_araddr[3:2]] : 32'h0;
                    RRESP  = (s_araddr < 32'h10) ? 2'b00 : 2'b10;
                end else begin
                    r_cnt--;
                end
            end
            since = (aw_got != w_got) ? since + 1 : 0;
            case (slave_mode)
                1: begin
                    AWREADY = !aw_got && ($urandom_range(1, 0) == 1);
                    WREADY  = !w_got && ($urandom_range(1, 0) == 1);
                    ARREADY = !ar_got && ($urandom_range(1, 0) == 1);
                end
                2: begin
                    AWREADY = !aw_got;
                    WREADY  = !w_got && aw_got && since >= 3;
                    ARREADY = !ar_got;
                end
                3: begin
                    AWREADY = !aw_got && w_got && since >= 3;
                    WREADY  = !w_got;
                    ARREADY = !ar_got;
                end
                default: begin
                    AWREADY = !aw_got;
                    WREADY  = !w_got;
                    ARREADY = !ar_got;
                end
            endcase
        end
    end

    function automatic bit all_idle();
        return cmdq0.size() == 0 && cmdq1.size() == 0 && slot_v == 2'b00 &&
               expq0.size() == 0 && expq1.size() == 0 && !BUSY;
    endfunction

    task automatic wait_idle(int budget);
        int n = 0;
        @(negedge clk);
        while (!all_idle() && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!all_idle()) begin
            checks++; errors++;
            $display("FAIL timeout: still busy after %0d cycles, expected idle", budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset(bit chk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_last = 1'b1;
        expq0.delete();
        expq1.delete();
        if (chk) begin
            checks++;
            if ({REQ_READY, RSP_VALID, RSP_RDATA, RSP_RESP, BUSY, AWVALID, WVALID,
                 BREADY, ARVALID, RREADY, AWADDR, ARADDR, WDATA, WSTRB} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: rdy=%b rsp=%b busy=%b awv=%b wv=%b arv=%b expected all 0",
                         REQ_READY, RSP_VALID, BUSY, AWVALID, WVALID, ARVALID);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push(int i, bit we, logic [31:0] addr, logic [31:0] data, logic [3:0] strb);
        cmd_t c;
        c.we = we; c.addr = addr; c.wdata = data; c.strb = strb;
        if (i == 0) cmdq0.push_back(c); else cmdq1.push_back(c);
    endtask

    task automatic check_log(string name, int exp_log[$]);
        checks++;
        if (grant_log != exp_log) begin
            errors++;
            $display("FAIL %s: grant order %p expected %p", name, grant_log, exp_log);
        end
        grant_log.delete();
    endtask

    initial begin : p_main
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[i] = 32'h0;
        do_reset(1'b1);

        // Single requester write then read-back.
        grant_log.delete();
        push(0, 1'b1, 32'h0, 32'h0101FFFF, 4'hF);
        push(0, 1'b0, 32'h0, 32'h0, 4'h0);
        wait_idle(200);
        check_log("single_req", '{0, 0});

        // Simultaneous requests from a fresh reset, then a repeated tie.
        do_reset(1'b0);
        push(0, 1'b1, 32'h4, 32'hABCD0001, 4'hF);
        push(1, 1'b0, 32'h4, 32'h0, 4'h0);
        wait_idle(200);
        push(0, 1'b1, 32'h4, 32'h5555AAAA, 4'h3);
        push(1, 1'b0, 32'h4, 32'h0, 4'h0);
        wait_idle(200);
        check_log("tie_alternate", '{0, 1, 0, 1});

        // Skewed AW/W acceptance in both directions.
        slave_mode = 2;
        push(0, 1'b1, 32'h8, 32'h12345678, 4'h5);
        push(0, 1'b0, 32'h8, 32'h0, 4'h0);
        wait_idle(200);
        slave_mode = 3;
        push(1, 1'b1, 32'hC, 32'hCAFEF00D, 4'hF);
        push(1, 1'b0, 32'hC, 32'h0, 4'h0);
        wait_idle(200);

        // Error responses are passed through.
        slave_mode = 0;
        push(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        push(1, 1'b0, 32'h10, 32'h0, 4'h0);
        wait_idle(200);
        grant_log.delete();

        // Continuous requester against an intermittent one.
        do_reset(1'b0);
        push(0, 1'b1, 32'h0, 32'h11111111, 4'hF);
        push(0, 1'b1, 32'h4, 32'h22222222, 4'hF);
        for (int k = 0; k < 4; k++) push(1, 1'b0, 32'(4 * k), 32'h0, 4'h0);
        wait_idle(400);
        check_log("fairness", '{0, 1, 0, 1, 1, 1});

        // Asynchronous reset while waiting for read data.
        slave_mode = 4;
        push(0, 1'b0, 32'h0, 32'h0, 4'h0);
        n = 0;
        while (RREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (RREADY !== 1'b1) begin
            errors++;
            $display("FAIL reach_rd_data: RREADY=%b expected 1", RREADY);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ARVALID, RREADY, RSP_VALID, BUSY} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset: arv=%b rr=%b rsp=%b busy=%b expected all 0",
                     ARVALID, RREADY, RSP_VALID, BUSY);
        end
        expq0.delete();
        expq1.delete();
        model_last = 1'b1;
        slave_mode = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(1, 1'b1, 32'h4, 32'h600DF00D, 4'hF);
        push(0, 1'b0, 32'h4, 32'h0, 4'h0);
        wait_idle(200);
        push(0, 1'b0, 32'h4, 32'h0, 4'h0);
        wait_idle(200);
        grant_log.delete();

        // Randomized traffic with random slave timing.
        slave_mode = 1;
        rand_gap   = 1'b1;
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 2; i++)
                push(i, 1'($urandom_range(1, 0)), 32'(4 * $urandom_range(4, 0)),
                     $urandom(), 4'($urandom_range(15, 0)));
        end
        wait_idle(5000);
        rand_gap = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
